// File: rtl/uart_rx_ovs.sv
// 16x-oversampling UART receiver: 2-FF synchronized line, start validation,
// 3-sample majority per bit, optional parity and stop-bit checking.
module uart_rx_ovs #(
  parameter int unsigned OVS_DIV    = 326,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RXD,
  output logic       rx_done,
  output logic [7:0] o_rx_data,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int unsigned DW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic          rxd_meta, rxd_sync, rxd_prev;
  logic [DW-1:0] div_cnt;
  logic [3:0]    s;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          v7, v8, par_bit;
  logic          tick, fall, vote;

  assign tick = (div_cnt == DW'(OVS_DIV - 1));
  assign fall = rxd_prev & ~rxd_sync;
  // Third vote sample is the live synchronized line at s=9.
  assign vote = (v7 & v8) | (v7 & rxd_sync) | (v8 & rxd_sync);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= RXD;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      s          <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      v7         <= 1'b0;
      v8         <= 1'b0;
      par_bit    <= 1'b0;
      rx_done    <= 1'b0;
      o_rx_data  <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (state == IDLE) begin
        div_cnt <= '0;
        s       <= '0;
        if (fall) begin
          state   <= START;
          bit_idx <= '0;
          rx_busy <= 1'b1;
        end
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          s <= s + 1'b1;
          if (s == 4'd7) v7 <= rxd_sync;
          if (s == 4'd8) v8 <= rxd_sync;
          case (state)
            START: begin
              if (s == 4'd9 && vote) begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else if (s == 4'd15) begin
                state <= DATA;
              end
            end
            DATA: begin
              if (s == 4'd9) shreg <= {vote, shreg[7:1]};
              if (s == 4'd15) begin
                bit_idx <= bit_idx + 1'b1;
                if (bit_idx == 3'd7) state <= PARITY_EN ? PARITY : STOP;
              end
            end
            PARITY: begin
              if (s == 4'd9) par_bit <= vote;
              if (s == 4'd15) state <= STOP;
            end
            STOP: begin
              // Leave at mid-stop so a start edge in its second half is caught.
              if (s == 4'd9) begin
                state      <= IDLE;
                rx_busy    <= 1'b0;
                rx_done    <= 1'b1;
                o_rx_data  <= shreg;
                frame_err  <= ~vote;
                parity_err <= PARITY_EN && ((^shreg ^ par_bit) != PARITY_ODD);
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
